lvt_memory_syn_harness: RTL and testbench

Parametrised serial-scan synthesis harness for the pipelined multi-port LVT memory (`lvt_memory_pipelined`). The harness replaces the free-running single-bit shift chain with a handshaked, SER_W-bit scan interface and a reset-able control FSM. The FSM runs one sequence per frame:

- scan in one full command frame (per-port enable, address and write data);
- issue it to the memory for exactly one cycle;
- wait the memory latency;
- capture all read ports;
- scan the result out.

It sits at the top of memory synthesis/characterisation builds so that PORTS×(AW+WIDTH) memory pins map onto a few device pins.

---
 rtl/lvt_memory_syn_harness.sv | 185 ++++++++++++++++++
 tb/tb_lvt_memory_syn_harness.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_memory_syn_harness.sv
// lvt_memory_syn_harness
//   Serial-scan harness around a pipelined multi-port memory. A handshaked
//   SER_W-bit scan port loads one command frame. The frame holds per-port
//   write enables, addresses and write data. The frame is issued to the
//   memory for one cycle. The read ports are captured after MEM_LAT cycles
//   and are then shifted out MSB first on a second handshaked scan port.
//
//   Ports
//     clk       sole clock
//     rst       synchronous active-high reset
//     si_valid  scan-in beat valid
//     si_data   scan-in beat (SER_W bits)
//     si_ready  harness accepts a scan-in beat (LOAD state)
//     so_valid  scan-out beat valid (UNLOAD state)
//     so_data   scan-out beat (SER_W bits, MSB first)
//     so_ready  consumer accepts the scan-out beat
//     busy      high in every state except LOAD
//     done      one-cycle pulse registered from the final accepted
//               scan-out beat
//
//   lvt_memory_pipelined (also in this file) is a behavioural memory with
//   the same port behaviour as the LVT memory:
//     - the registered address is read every cycle;
//     - port j writes when i_en && i_we[j];
//     - a read issued in the same cycle as a write returns the old word;
//     - q appears MEM_LAT cycles after the address cycle.

module lvt_memory_pipelined #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 512,
   parameter int PORTS   = 32,
   parameter int MEM_LAT = 3,
   parameter int AW      = 9
) (
   input  logic                     clk,
   input  logic                     i_en,
   input  logic [PORTS-1:0]         i_we,
   input  logic [PORTS*AW-1:0]      i_addr,
   input  logic [PORTS*WIDTH-1:0]   i_d,
   output logic [PORTS*WIDTH-1:0]   o_q
);
   logic [WIDTH-1:0]       r_mem  [DEPTH];
   logic [PORTS*WIDTH-1:0] r_q_p  [MEM_LAT];

   always_ff @(posedge clk) begin
      // stage 0: array read (old data on a same-cycle write)
      for (int j = 0; j < PORTS; j++)
         r_q_p[0][j*WIDTH +: WIDTH] <= r_mem[i_addr[j*AW +: AW]];
      // stages 1..MEM_LAT-1: read-data delay line
      for (int k = 1; k < MEM_LAT; k++)
         r_q_p[k] <= r_q_p[k-1];
      for (int j = 0; j < PORTS; j++)
         if (i_en && i_we[j])
            r_mem[i_addr[j*AW +: AW]] <= i_d[j*WIDTH +: WIDTH];
   end

   assign o_q = r_q_p[MEM_LAT-1];
endmodule

module lvt_memory_syn_harness #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 512,
   parameter int PORTS   = 32,
   parameter int SER_W   = 1,
   parameter int MEM_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si_valid,
   input  logic [SER_W-1:0] si_data,
   output logic             si_ready,
   output logic             so_valid,
   output logic [SER_W-1:0] so_data,
   input  logic             so_ready,
   output logic             busy,
   output logic             done
);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int F     = PORTS * (AW + WIDTH + 1);
   localparam int N_IN  = (F + SER_W - 1) / SER_W;
   localparam int IN_W  = N_IN * SER_W;
   localparam int G     = PORTS * WIDTH;
   localparam int N_OUT = (G + SER_W - 1) / SER_W;
   localparam int OUT_W = N_OUT * SER_W;
   localparam int ICW   = $clog2(N_IN + 1);
   localparam int OCW   = $clog2(N_OUT + 1);
   localparam int LCW   = $clog2(MEM_LAT + 1);

   typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_CAPTURE, S_UNLOAD} state_t;

   state_t             r_state, w_next;
   logic [IN_W-1:0]    r_in;
   logic [OUT_W-1:0]   r_out;
   logic [ICW-1:0]     r_in_cnt;
   logic [OCW-1:0]     r_out_cnt;
   logic [LCW-1:0]     r_lat_cnt;
   logic               r_mem_en;
   logic [PORTS-1:0]   r_mem_we;
   logic [PORTS*AW-1:0] r_mem_addr;
   logic [G-1:0]       r_mem_d;
   logic               r_done;
   logic [G-1:0]       w_q;
   logic               w_si_acc, w_so_acc, w_in_last, w_out_last, w_lat_last;

   assign w_si_acc   = (r_state == S_LOAD) && si_valid;
   assign w_so_acc   = (r_state == S_UNLOAD) && so_ready;
   assign w_in_last  = w_si_acc && (r_in_cnt == ICW'(N_IN - 1));
   assign w_out_last = w_so_acc && (r_out_cnt == OCW'(N_OUT - 1));
   // WAIT starts in the mem_en cycle, so MEM_LAT WAIT cycles end right
   // before the cycle in which q is valid.
   assign w_lat_last = (r_state == S_WAIT) && (r_lat_cnt == LCW'(MEM_LAT - 1));

   lvt_memory_pipelined #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .MEM_LAT(MEM_LAT), .AW(AW)
   ) u_mem (
      .clk    (clk),
      .i_en   (r_mem_en),
      .i_we   (r_mem_we),
      .i_addr (r_mem_addr),
      .i_d    (r_mem_d),
      .o_q    (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:    if (w_in_last)  w_next = S_ISSUE;
         S_ISSUE:                   w_next = S_WAIT;
         S_WAIT:    if (w_lat_last) w_next = S_CAPTURE;
         S_CAPTURE:                 w_next = S_UNLOAD;
         S_UNLOAD:  if (w_out_last) w_next = S_LOAD;
         default:                   w_next = S_LOAD;
      endcase
   end

   always_comb begin
      si_ready = (r_state == S_LOAD);
      busy     = (r_state != S_LOAD);
      so_valid = (r_state == S_UNLOAD);
      so_data  = r_out[OUT_W-1 -: SER_W];
      done     = r_done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in       <= '0;
         r_out      <= '0;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_lat_cnt  <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= '0;
         r_mem_addr <= '0;
         r_mem_d    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done   <= w_out_last;
         r_mem_en <= 1'b0;
         if (w_si_acc) begin
            // newest beat enters the LSBs; leading pad falls off the top
            r_in     <= (r_in << SER_W) | IN_W'(si_data);
            r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
         end
         if (r_state == S_ISSUE) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= r_in[PORTS-1:0];
            r_mem_addr <= r_in[PORTS +: PORTS*AW];
            r_mem_d    <= r_in[PORTS + PORTS*AW +: G];
         end
         if (r_state == S_WAIT)
            r_lat_cnt <= w_lat_last ? '0 : r_lat_cnt + 1'b1;
         if (r_state == S_CAPTURE)
            r_out <= OUT_W'(w_q);
         if (w_so_acc) begin
            r_out     <= r_out << SER_W;
            r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lvt_memory_syn_harness.sv
module tb_lvt_memory_syn_harness;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_si_valid, a_si_ready, a_so_valid, a_so_ready, a_busy, a_done;
   logic [3:0] a_si_data, a_so_data;
   logic       b_si_valid, b_si_ready, b_so_valid, b_so_ready, b_busy, b_done;
   logic [2:0] b_si_data, b_so_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference memory contents per instance (0: SER_W=4, 1: SER_W=3)
   logic [3:0] mm [2][8];

   lvt_memory_syn_harness #(.WIDTH(4), .DEPTH(8), .PORTS(2), .SER_W(4), .MEM_LAT(3)) dut_a (
      .clk(clk), .rst(rst), .si_valid(a_si_valid), .si_data(a_si_data), .si_ready(a_si_ready),
      .so_valid(a_so_valid), .so_data(a_so_data), .so_ready(a_so_ready), .busy(a_busy), .done(a_done));

   lvt_memory_syn_harness #(.WIDTH(4), .DEPTH(8), .PORTS(2), .SER_W(3), .MEM_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .si_valid(b_si_valid), .si_data(b_si_data), .si_ready(b_si_ready),
      .so_valid(b_so_valid), .so_data(b_so_data), .so_ready(b_so_ready), .busy(b_busy), .done(b_done));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] mkframe(input logic [1:0] we, input logic [2:0] a0, input logic [2:0] a1,
                                           input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] pad);
      return {pad, d1, d0, a1, a0, we};
   endfunction

   function automatic logic get_si_ready(input int sel); return (sel == 0) ? a_si_ready : b_si_ready; endfunction
   function automatic logic get_so_valid(input int sel); return (sel == 0) ? a_so_valid : b_so_valid; endfunction
   function automatic logic get_busy(input int sel);     return (sel == 0) ? a_busy : b_busy;         endfunction
   function automatic logic get_done(input int sel);     return (sel == 0) ? a_done : b_done;         endfunction
   function automatic logic get_men(input int sel);      return (sel == 0) ? dut_a.r_mem_en : dut_b.r_mem_en; endfunction
   function automatic logic [3:0] get_so_data(input int sel);
      return (sel == 0) ? a_so_data : {1'b0, b_so_data};
   endfunction

   task automatic drive_si(input int sel, input logic v, input logic [3:0] d);
      if (sel == 0) begin a_si_valid = v; a_si_data = d; end
      else          begin b_si_valid = v; b_si_data = d[2:0]; end
   endtask

   task automatic set_so_ready(input int sel, input logic r);
      if (sel == 0) a_so_ready = r; else b_so_ready = r;
   endtask

   // Reference: every port reads its address before any write of the frame lands.
   task automatic model_commit(input int sel, input logic [17:0] f, output logic [7:0] q);
      logic [2:0] a0, a1;
      a0 = f[4:2];
      a1 = f[7:5];
      q = {mm[sel][a1], mm[sel][a0]};
      if (f[0]) mm[sel][a0] = f[11:8];
      if (f[1]) mm[sel][a1] = f[15:12];
   endtask

   task automatic scan_in(input int sel, input logic [17:0] f, input bit gaps);
      int s, n;
      logic [17:0] t;
      s = (sel == 0) ? 4 : 3;
      n = (sel == 0) ? 4 : 6;
      for (int b = 0; b < n; b++) begin
         if (gaps) begin
            drive_si(sel, 1'b0, 4'($urandom));
            @(negedge clk);
         end
         t = f >> ((n - 1 - b) * s);
         drive_si(sel, 1'b1, (sel == 0) ? t[3:0] : {1'b0, t[2:0]});
         check("si_ready_load", 32'(get_si_ready(sel)), 32'd1);
         @(negedge clk);
      end
      drive_si(sel, 1'b0, 4'd0);
   endtask

   task automatic drain(input int sel, input logic [7:0] q, input bit chkdata, input int stall, input int last_cyc);
      int s, n, k, t, men_cnt, men_cyc, st;
      bit first, hs;
      logic [8:0] oz, sh;
      logic [3:0] ex;
      s = (sel == 0) ? 4 : 3;
      n = (sel == 0) ? 2 : 3;
      oz = {1'b0, q};
      k = 0; t = 0; men_cnt = 0; men_cyc = -1; st = stall; first = 1'b1;
      while (k < n && t < 80) begin
         if (get_men(sel)) begin
            men_cnt++;
            if (men_cyc < 0) men_cyc = cyc;
         end
         hs = 1'b0;
         if (get_so_valid(sel)) begin
            if (first) begin
               check("so_valid_latency", 32'(cyc), 32'(men_cyc + 4));
               first = 1'b0;
            end
            sh = oz >> ((n - 1 - k) * s);
            ex = (sel == 0) ? sh[3:0] : {1'b0, sh[2:0]};
            if (chkdata) check("so_data", 32'(get_so_data(sel)), 32'(ex));
            check("busy_unload", 32'(get_busy(sel)), 32'd1);
            if (st > 0) begin st--; set_so_ready(sel, 1'b0); end
            else begin set_so_ready(sel, 1'b1); hs = 1'b1; end
         end else begin
            set_so_ready(sel, 1'b0);
         end
         check("done_low", 32'(get_done(sel)), 32'd0);
         @(negedge clk);
         t++;
         if (hs) k++;
      end
      set_so_ready(sel, 1'b0);
      check("unload_beats", 32'(k), 32'(n));
      check("done_pulse", 32'(get_done(sel)), 32'd1);
      check("so_valid_after", 32'(get_so_valid(sel)), 32'd0);
      check("si_ready_after", 32'(get_si_ready(sel)), 32'd1);
      check("mem_en_count", 32'(men_cnt), 32'd1);
      check("mem_en_latency", 32'(men_cyc), 32'(last_cyc + 1));
      @(negedge clk);
      check("done_one_cycle", 32'(get_done(sel)), 32'd0);
   endtask

   task automatic run_frame(input int sel, input logic [17:0] f, input bit gaps, input int stall, input bit chkdata);
      logic [7:0] q;
      int lc;
      model_commit(sel, f, q);
      scan_in(sel, f, gaps);
      lc = cyc;
      drain(sel, q, chkdata, stall, lc);
   endtask

   task automatic check_reset_state(input int sel, input string tag);
      check({tag, "_si_ready"}, 32'(get_si_ready(sel)), 32'd1);
      check({tag, "_busy"},     32'(get_busy(sel)), 32'd0);
      check({tag, "_so_valid"}, 32'(get_so_valid(sel)), 32'd0);
      check({tag, "_done"},     32'(get_done(sel)), 32'd0);
      check({tag, "_mem_en"},   32'(get_men(sel)), 32'd0);
   endtask

   task automatic init_mem(input int sel);
      for (int i = 0; i < 4; i++)
         run_frame(sel, mkframe(2'b11, 3'(2 * i), 3'(2 * i + 1), 4'($urandom), 4'($urandom), 2'($urandom)),
                   1'b0, 0, 1'b0);
   endtask

   task automatic random_frames(input int sel, input int cnt);
      logic [1:0] we;
      logic [2:0] a0, a1;
      for (int i = 0; i < cnt; i++) begin
         we = 2'($urandom);
         a0 = 3'($urandom);
         a1 = 3'($urandom);
         if (we == 2'b11 && a0 == a1) we = 2'b10;
         run_frame(sel, mkframe(we, a0, a1, 4'($urandom), 4'($urandom), 2'($urandom)),
                   1'($urandom), int'($urandom_range(0, 3)), 1'b1);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive_si(0, 1'b0, 4'd0);
      drive_si(1, 1'b0, 4'd0);
      a_so_ready = 1'b0;
      b_so_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state(0, "rst_a");
      check_reset_state(1, "rst_b");
      check("rst_a_so_data", 32'(a_so_data), 32'd0);
      check("rst_b_so_data", 32'(b_so_data), 32'd0);

      // SER_W=4: fill memory, then write addr5=0xA and read it back on both ports
      init_mem(0);
      run_frame(0, 18'h00A15, 1'b0, 0, 1'b1);
      run_frame(0, 18'h000B4, 1'b0, 0, 1'b1);

      // same scenario with input gaps and a 5-cycle output stall
      run_frame(0, mkframe(2'b01, 3'd5, 3'd0, 4'h6, 4'h0, 2'b00), 1'b1, 5, 1'b1);
      run_frame(0, 18'h00A15, 1'b1, 5, 1'b1);
      run_frame(0, 18'h000B4, 1'b1, 5, 1'b1);

      // reset while the write frame sits in ISSUE: the write must never fire
      scan_in(0, mkframe(2'b01, 3'd5, 3'd0, 4'h3, 4'h0, 2'b00), 1'b0);
      check("issue_busy", 32'(a_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state(0, "rst_issue");
      for (int i = 0; i < 6; i++) begin
         check("rst_issue_no_mem_en", 32'(get_men(0)), 32'd0);
         @(negedge clk);
      end
      run_frame(0, 18'h000B4, 1'b0, 0, 1'b1);

      // reset in the second WAIT cycle
      scan_in(0, mkframe(2'b00, 3'd5, 3'd1, 4'h0, 4'h0, 2'b00), 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("wait_busy", 32'(a_busy), 32'd1);
      check("wait_so_valid", 32'(a_so_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state(0, "rst_wait");
      for (int i = 0; i < 6; i++) begin
         check("rst_wait_no_mem_en", 32'(get_men(0)), 32'd0);
         check("rst_wait_no_so_valid", 32'(a_so_valid), 32'd0);
         @(negedge clk);
      end
      run_frame(0, 18'h000B4, 1'b0, 0, 1'b1);

      random_frames(0, 20);

      // SER_W=3: two leading pad bits are discarded, first out beat carries a zero pad
      init_mem(1);
      run_frame(1, {2'b11, 16'h0A15}, 1'b0, 0, 1'b1);
      run_frame(1, {2'b10, 16'h00B4}, 1'b0, 0, 1'b1);
      run_frame(1, {2'b01, 16'h00B4}, 1'b1, 5, 1'b1);
      random_frames(1, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
